// File: rtl/srio_pkg.sv
// Shared SRIO definitions: AXIS widths, HELLO header TID field position and
// the request arbiter state encoding.
package srio_pkg;

   localparam int unsigned AxisDataW = 64;
   localparam int unsigned AxisKeepW = 8;
   localparam int unsigned AxisUserW = 32;

   // HELLO header TID field occupies tdata[63:56]
   localparam int unsigned TidMsb = 63;
   localparam int unsigned TidLsb = 56;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } req_state_e;

endpackage

// File: rtl/srio_rr_picker.sv
// Combinational round-robin select: first set request searching upward,
// cyclically, from i_rr_ptr+1.
module srio_rr_picker #(
   parameter int unsigned P_REQ_NUM = 4,
   parameter int unsigned P_IDX_W   = 2
) (
   input  logic [P_REQ_NUM-1:0] i_req,
   input  logic [P_IDX_W-1:0]   i_rr_ptr,
   output logic                 o_valid,
   output logic [P_IDX_W-1:0]   o_idx
);

   logic [P_IDX_W-1:0] w_cand;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int unsigned i = 1; i <= P_REQ_NUM; i++) begin
         w_cand = P_IDX_W'((32'(i_rr_ptr) + i) % P_REQ_NUM);
         if (!o_valid && i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/srio_ireq_arbiter.sv
// Packet-level round-robin arbiter for one SRIO ireq port; tags request TIDs
// with the requester index and demultiplexes iresp packets on the same bits.
module srio_ireq_arbiter
   import srio_pkg::*;
#(
   parameter int unsigned P_REQ_NUM = 4,
   parameter int unsigned P_IDX_W   = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_port_initialized,
   input  logic [P_REQ_NUM-1:0]           s_req_axis_tvalid,
   output logic [P_REQ_NUM-1:0]           s_req_axis_tready,
   input  logic [P_REQ_NUM-1:0]           s_req_axis_tlast,
   input  logic [P_REQ_NUM*AxisDataW-1:0] s_req_axis_tdata,
   input  logic [P_REQ_NUM*AxisKeepW-1:0] s_req_axis_tkeep,
   input  logic [P_REQ_NUM*AxisUserW-1:0] s_req_axis_tuser,
   output logic                           m_axis_ireq_tvalid,
   input  logic                           m_axis_ireq_tready,
   output logic                           m_axis_ireq_tlast,
   output logic [AxisDataW-1:0]           m_axis_ireq_tdata,
   output logic [AxisKeepW-1:0]           m_axis_ireq_tkeep,
   output logic [AxisUserW-1:0]           m_axis_ireq_tuser,
   input  logic                           s_axis_iresp_tvalid,
   output logic                           s_axis_iresp_tready,
   input  logic                           s_axis_iresp_tlast,
   input  logic [AxisDataW-1:0]           s_axis_iresp_tdata,
   input  logic [AxisKeepW-1:0]           s_axis_iresp_tkeep,
   input  logic [AxisUserW-1:0]           s_axis_iresp_tuser,
   output logic [P_REQ_NUM-1:0]           m_rsp_axis_tvalid,
   input  logic [P_REQ_NUM-1:0]           m_rsp_axis_tready,
   output logic [P_REQ_NUM-1:0]           m_rsp_axis_tlast,
   output logic [P_REQ_NUM*AxisDataW-1:0] m_rsp_axis_tdata,
   output logic [P_REQ_NUM*AxisKeepW-1:0] m_rsp_axis_tkeep,
   output logic [P_REQ_NUM*AxisUserW-1:0] m_rsp_axis_tuser,
   output logic [P_REQ_NUM-1:0]           o_grant,
   output logic                           o_rsp_misroute
);

   req_state_e             r_state;
   req_state_e             w_state_nxt;
   logic [P_REQ_NUM-1:0]   r_grant;
   logic [P_IDX_W-1:0]     r_gidx;
   logic [P_IDX_W-1:0]     r_rr_ptr;
   logic                   r_hdr;
   logic                   w_pick_valid;
   logic [P_IDX_W-1:0]     w_pick_idx;
   logic                   w_start;
   logic                   w_req_acc;
   logic                   w_req_end;
   logic [AxisDataW-1:0]   w_req_data [P_REQ_NUM];
   logic [AxisKeepW-1:0]   w_req_keep [P_REQ_NUM];
   logic [AxisUserW-1:0]   w_req_user [P_REQ_NUM];

   logic                   r_rsp_first;
   logic [P_IDX_W-1:0]     r_route;
   logic                   r_misroute;
   logic [P_IDX_W-1:0]     w_route;
   logic                   w_route_bad;
   logic                   w_sel_ready;
   logic                   w_rsp_acc;

   srio_rr_picker #(
      .P_REQ_NUM (P_REQ_NUM),
      .P_IDX_W   (P_IDX_W)
   ) u_picker (
      .i_req    (s_req_axis_tvalid),
      .i_rr_ptr (r_rr_ptr),
      .o_valid  (w_pick_valid),
      .o_idx    (w_pick_idx)
   );

   always_comb begin
      for (int k = 0; k < int'(P_REQ_NUM); k++) begin
         w_req_data[k] = s_req_axis_tdata[k*AxisDataW +: AxisDataW];
         w_req_keep[k] = s_req_axis_tkeep[k*AxisKeepW +: AxisKeepW];
         w_req_user[k] = s_req_axis_tuser[k*AxisUserW +: AxisUserW];
      end
   end

   assign w_start   = (r_state == StIdle) && i_port_initialized && w_pick_valid;
   assign w_req_acc = m_axis_ireq_tvalid && m_axis_ireq_tready;
   assign w_req_end = w_req_acc && m_axis_ireq_tlast;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: if (w_start) w_state_nxt = StBusy;
         StBusy: if (w_req_end) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant  <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= P_IDX_W'(P_REQ_NUM - 1);
         r_hdr    <= 1'b1;
      end else if (w_start) begin
         r_grant <= {{(P_REQ_NUM-1){1'b0}}, 1'b1} << w_pick_idx;
         r_gidx  <= w_pick_idx;
         r_hdr   <= 1'b1;
      end else if ((r_state == StBusy) && w_req_acc) begin
         r_hdr <= 1'b0;
         if (m_axis_ireq_tlast) begin
            r_grant  <= '0;
            r_rr_ptr <= r_gidx;
         end
      end
   end

   // Only the first beat of a packet is a header carrying the TID
   always_comb begin
      m_axis_ireq_tvalid = 1'b0;
      m_axis_ireq_tlast  = 1'b0;
      m_axis_ireq_tdata  = '0;
      m_axis_ireq_tkeep  = '0;
      m_axis_ireq_tuser  = '0;
      s_req_axis_tready  = '0;
      if (r_state == StBusy) begin
         m_axis_ireq_tvalid = s_req_axis_tvalid[r_gidx];
         m_axis_ireq_tlast  = s_req_axis_tlast[r_gidx];
         m_axis_ireq_tdata  = w_req_data[r_gidx];
         m_axis_ireq_tkeep  = w_req_keep[r_gidx];
         m_axis_ireq_tuser  = w_req_user[r_gidx];
         if (r_hdr) m_axis_ireq_tdata[TidMsb -: P_IDX_W] = r_gidx;
         s_req_axis_tready[r_gidx] = m_axis_ireq_tready;
      end
   end

   assign o_grant = r_grant;

   // Response router: route comes live from the header, then is held until tlast
   assign w_route     = r_rsp_first ? s_axis_iresp_tdata[TidMsb -: P_IDX_W] : r_route;
   assign w_route_bad = (32'(w_route) >= P_REQ_NUM);
   assign w_rsp_acc   = s_axis_iresp_tvalid && s_axis_iresp_tready;

   always_comb begin
      m_rsp_axis_tvalid = '0;
      w_sel_ready       = 1'b0;
      for (int k = 0; k < int'(P_REQ_NUM); k++) begin
         if (w_route == P_IDX_W'(k)) begin
            m_rsp_axis_tvalid[k] = i_rst_n && s_axis_iresp_tvalid;
            w_sel_ready          = m_rsp_axis_tready[k];
         end
      end
      s_axis_iresp_tready = i_rst_n && (w_route_bad || w_sel_ready);
      m_rsp_axis_tlast    = {P_REQ_NUM{i_rst_n && s_axis_iresp_tlast}};
      m_rsp_axis_tdata    = i_rst_n ? {P_REQ_NUM{s_axis_iresp_tdata}} : '0;
      m_rsp_axis_tkeep    = i_rst_n ? {P_REQ_NUM{s_axis_iresp_tkeep}} : '0;
      m_rsp_axis_tuser    = i_rst_n ? {P_REQ_NUM{s_axis_iresp_tuser}} : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_first <= 1'b1;
         r_route     <= '0;
         r_misroute  <= 1'b0;
      end else begin
         if (w_rsp_acc) begin
            r_rsp_first <= s_axis_iresp_tlast;
            if (r_rsp_first) r_route <= w_route;
         end
         if (w_rsp_acc && r_rsp_first && w_route_bad) r_misroute <= 1'b1;
      end
   end

   assign o_rsp_misroute = r_misroute;

endmodule

// File: doc/srio_ireq_arbiter.md
# srio_ireq_arbiter

Packet-level round-robin arbiter that shares one SRIO channel's initiator request port (`ireq`) among `P_REQ_NUM` local requesters and routes returning initiator responses (`iresp`) back to the requester that issued them. It sits between user request generators and one SRIO channel's `ireq`/`iresp` AXI-Stream ports, in that channel's `log_clk` domain. Routing is by TID tagging: the arbiter overwrites the top TID bits of every request header with the requester index, then demultiplexes responses on the same bits.

## Interface
Parameters:
- `P_REQ_NUM`, default 4: number of requesters, 2..8.
- `P_IDX_W`, default 2: index width, equal to clog2(`P_REQ_NUM`); these are the TID bits the arbiter owns.

Ports (requester buses are flattened; requester k occupies slice k):
- `i_clk` in 1: channel `log_clk`; single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_port_initialized` in 1: SRIO port is up; no grant is issued while low.
- `s_req_axis_tvalid`/`tready`/`tlast` in/out/in, `P_REQ_NUM` each: requester request streams.
- `s_req_axis_tdata` in `P_REQ_NUM`*64; `s_req_axis_tkeep` in `P_REQ_NUM`*8; `s_req_axis_tuser` in `P_REQ_NUM`*32.
- `m_axis_ireq_tvalid`/`tready`/`tlast` out/in/out, 1 each; `m_axis_ireq_tdata` out 64; `m_axis_ireq_tkeep` out 8; `m_axis_ireq_tuser` out 32: to the core `ireq`.
- `s_axis_iresp_tvalid`/`tready`/`tlast` in/out/in, 1 each; `s_axis_iresp_tdata` in 64; `s_axis_iresp_tkeep` in 8; `s_axis_iresp_tuser` in 32: from the core `iresp`.
- `m_rsp_axis_tvalid`/`tready`/`tlast` out/in/out, `P_REQ_NUM` each; `m_rsp_axis_tdata` out `P_REQ_NUM`*64; `m_rsp_axis_tkeep` out `P_REQ_NUM`*8; `m_rsp_axis_tuser` out `P_REQ_NUM`*32: per-requester responses.
- `o_grant` out `P_REQ_NUM`: one-hot current owner of the `ireq` port; 0 when idle.
- `o_rsp_misroute` out 1: sticky flag, set when a response arrives with an index ≥ `P_REQ_NUM`.

## Operation
- Request FSM has two states, IDLE and BUSY.
- IDLE:
  - If `i_port_initialized`=1 and any `s_req_axis_tvalid` is set, select the first valid requester searching upward, cyclically, from `rr_ptr`+1.
  - Register the winner in `o_grant` and go to BUSY.
- BUSY, with g the granted requester:
  - `m_axis_ireq_*` = requester g's signals; `s_req_axis_tready[g]` = `m_axis_ireq_tready`; every other `tready` is 0.
  - On the first beat of the packet (the header), `tdata[63:64-P_IDX_W]` is replaced by g. All other beats pass through unmodified.
  - When a beat with `tlast` is accepted (valid & ready & last): go to IDLE, clear `o_grant`, and set `rr_ptr` to g.
- A packet is never truncated. If `i_port_initialized` falls during BUSY, the current packet finishes; no new grant follows.
- Response path:
  - A `first` flag is set after reset and after every accepted `tlast` beat.
  - On a first beat, route = `tdata[63:64-P_IDX_W]` (combinational). The route is registered on acceptance and held until that packet's `tlast`.
  - `m_rsp_axis_tvalid[route]` = `s_axis_iresp_tvalid`; `s_axis_iresp_tready` = `m_rsp_axis_tready[route]`. Data, keep, user and last are broadcast to all requester slices.
  - Route ≥ `P_REQ_NUM`: the packet is discarded (`tready`=1 for the whole packet) and `o_rsp_misroute` is set. It clears only on reset.
- Requesters own only the low 8-`P_IDX_W` TID bits; returned TIDs carry the index bits.

## Timing
- Reset state: IDLE; `o_grant`=0; `rr_ptr`=`P_REQ_NUM`-1, so requester 0 wins first; `m_axis_ireq_tvalid`=0; all `s_req_axis_tready`=0; `first`=1; `o_rsp_misroute`=0. All outputs are 0 during reset.
- Grant latency: 1 cycle from a valid request in IDLE to the first beat on `m_axis_ireq`. There is exactly one idle cycle between back-to-back packets.
- Data path is combinational through the mux from registered grant state; no data registers.
- Response path is zero-latency pass-through.
- Simultaneous requests in IDLE: strict rotation from `rr_ptr`. A requester that wins is lowest priority for the next decision.
- A requester deasserting `tvalid` mid-packet holds the grant; no timeout.
- Response and request paths are independent; both may be active in the same cycle.
- Reset asserted mid-packet aborts both paths immediately with no flush. Callers are reset from the same source.

## Structure
- Shared package `srio_pkg` holds:
  - the HELLO header TID field position (bits 63:56);
  - the AXIS widths 64/8/32;
  - the FSM state encoding (IDLE/BUSY).
- One sub-module, `srio_rr_picker`: combinational one-hot round-robin select, with inputs request vector and `rr_ptr`, output winner index.
- Arbiter FSM and response router stay in the top module.

## Test plan
- Reset, then requester 2 sends a 3-beat packet with header TID 0x15 → `o_grant`=0100 one cycle later; ireq header TID=0x95; 3 beats; `o_grant` returns to 0 after `tlast`.
- All 4 requesters hold 1-beat packets continuously → grant order 0,1,2,3,0 with one idle cycle between packets.
- `m_axis_ireq_tready` toggles 1/0 during a 4-beat packet from requester 1 → no beat lost or duplicated; other requesters' `tready` stays 0.
- `i_port_initialized` drops mid-packet → packet completes; no further grant until it returns to 1.
- iresp packet with TID 0xC7, 2 beats → delivered only on `m_rsp` slice 3; backpressure on `m_rsp_axis_tready[3]` stalls `s_axis_iresp_tready`.
- `P_REQ_NUM`=3 and a response with TID 0xC0 → packet dropped, `tready`=1 throughout, `o_rsp_misroute`=1 until reset.
